// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared segment patterns (gfedcba, active-low) and special digit
//            codes for the multiplexed 7-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_UNDER = 7'b1110111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_UNDER = 4'hC;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational nibble to active-low gfedcba segment decoder.
//            0..9 are digits, A/B/C are dash/blank/underscore, D..F all-on.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Map each code to its segment pattern; unused codes light everything.
    always_comb begin
        seg = SEG_ALL;
        case (nib)
            4'h0:       seg = SEG_0;
            4'h1:       seg = SEG_1;
            4'h2:       seg = SEG_2;
            4'h3:       seg = SEG_3;
            4'h4:       seg = SEG_4;
            4'h5:       seg = SEG_5;
            4'h6:       seg = SEG_6;
            4'h7:       seg = SEG_7;
            4'h8:       seg = SEG_8;
            4'h9:       seg = SEG_9;
            CODE_DASH:  seg = SEG_DASH;
            CODE_BLANK: seg = SEG_BLANK;
            CODE_UNDER: seg = SEG_UNDER;
            default:    seg = SEG_ALL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_n
// Purpose  : Time-multiplexed common-anode 7-segment driver for DIGITS digits
//            with decimal-point mask, leading-zero suppression and a one-cycle
//            dark guard on every digit change. All outputs are registered.
//            Optional build macro SEG7_PWM_EN gates the anode with a 16-step
//            brightness PWM driven by the bright input.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 262144
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);

    localparam int              CW         = $clog2(SCAN_DIV);
    localparam int              IW         = $clog2(DIGITS);
    localparam logic [CW-1:0]   c_div_last = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   c_idx_last = IW'(DIGITS - 1);

    logic [CW-1:0]     r_div_cnt;
    logic [CW-1:0]     w_div_nxt;
    logic              w_adv;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nxt;
    logic              r_scan_on;
    logic [DIGITS-1:0] w_hi_zero;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;
    logic              w_supp;
    logic              w_dp_on;
    logic [DIGITS-1:0] w_an_sel;
    logic [DIGITS-1:0] w_an_nxt;

    assign w_adv     = (r_div_cnt == c_div_last);
    assign w_div_nxt = w_adv ? '0 : r_div_cnt + 1'b1;
    assign w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    assign w_nib     = x[{w_idx_nxt, 2'b00} +: 4];

    // w_hi_zero[i] is set when digit i and every digit to its left are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hz
        assign w_hi_zero[gi] = ~|x[4*DIGITS-1:4*gi];
    end

    // Digit 0 always shows, so a value of zero still reads "0".
    assign w_supp   = blank_lz & (w_idx_nxt != '0) & w_hi_zero[w_idx_nxt];
    assign w_dp_on  = dp_mask[w_idx_nxt] & ~w_supp;
    assign w_an_sel = ~(DIGITS'(1) << r_idx);

    seg7_decode u_decode (
        .nib (w_nib),
        .seg (w_seg)
    );

    // Next anode value: dark on the advance edge (guard), the selected digit
    // afterwards once scanning has started; optionally PWM-gated.
    always_comb begin
        w_an_nxt = '1;
        if (!w_adv && r_scan_on) begin
`ifdef SEG7_PWM_EN
            if (w_div_nxt[3:0] <= bright) begin
                w_an_nxt = w_an_sel;
            end
`else
            w_an_nxt = w_an_sel;
`endif
        end
    end

`ifndef SEG7_PWM_EN
    logic w_unused_bright;
    assign w_unused_bright = ^bright;
`endif

    // Scan timebase and digit index; nothing lights before the first advance.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
            r_scan_on <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            if (w_adv) begin
                r_idx     <= w_idx_nxt;
                r_scan_on <= 1'b1;
            end
        end
    end

    // Output registers: segments/dp load only at an advance, anode every cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_to_g <= SEG_BLANK;
            dp     <= 1'b1;
            an     <= '1;
        end else begin
            if (w_adv) begin
                a_to_g <= w_supp ? SEG_BLANK : w_seg;
                dp     <= ~w_dp_on;
            end
            an <= w_an_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_n
// Purpose  : Self-checking bench for seg7_scan_n (DIGITS=4, SCAN_DIV=32).
//            Stimulus queues the expected digit picture for each scan slot;
//            a monitor pops one entry each time a digit lights up.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_n;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 32;
    localparam int LIMIT    = 10 * SCAN_DIV;

    logic        clk      = 1'b0;
    logic        clr      = 1'b1;
    logic [15:0] x        = 16'h0000;
    logic [3:0]  dp_mask  = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright   = 4'd15;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    int   nidx   = 1;

    always #5 clk = ~clk;

    seg7_scan_n #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .x        (x),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .bright   (bright),
        .a_to_g   (a_to_g),
        .an       (an),
        .dp       (dp)
    );

    // Monitor: pops an expectation at every digit light-up, checks that the
    // picture holds for the whole lit phase and that each guard is 1 cycle.
    always @(negedge clk) begin : mon
        static bit   prev_lit = 1'b0;
        static bit   seen     = 1'b0;
        static bit   changed  = 1'b0;
        static int   dark_len = 0;
        static exp_t cur      = '0;
        bit          lit;
        if (clr) begin
            prev_lit = 1'b0;
            seen     = 1'b0;
            dark_len = 0;
        end else if (mon_en) begin
            lit = (an != 4'hF);
            if (lit && !prev_lit) begin
                if (seen) begin
                    n_cmp++;
                    if (dark_len != 1) begin
                        n_fail++;
                        $display("FAIL guard_len: got %0d dark cycles, expected 1", dark_len);
                    end
                end
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_digit: an=%b seg=%b dp=%b with nothing expected", an, a_to_g, dp);
                end else begin
                    cur = q.pop_front();
                    if ({an, a_to_g, dp} != {cur.an, cur.seg, cur.dp}) begin
                        n_fail++;
                        $display("FAIL digit: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                                 an, a_to_g, dp, cur.an, cur.seg, cur.dp);
                    end
                end
                seen    = 1'b1;
                changed = 1'b0;
            end else if (lit) begin
                if ({an, a_to_g, dp} != {cur.an, cur.seg, cur.dp}) changed = 1'b1;
            end else if (prev_lit) begin
                n_cmp++;
                if (changed) begin
                    n_fail++;
                    $display("FAIL hold: picture changed during lit phase, expected seg=%b dp=%b an=%b",
                             cur.seg, cur.dp, cur.an);
                end
                dark_len = 0;
            end
            if (!lit) dark_len++;
            prev_lit = lit;
        end
    end

    task automatic push_exp(input logic [6:0] seg, input logic dp_e);
        exp_t       e;
        logic [3:0] one = 4'b0001;
        e.an  = ~(one << nidx);
        e.seg = seg;
        e.dp  = dp_e;
        q.push_back(e);
        nidx = (nidx == DIGITS - 1) ? 0 : nidx + 1;
    endtask

    // Patterns given left to right (digit 3 .. digit 0); dpv[i] is digit i's dp.
    task automatic push4(input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0,
                         input logic [3:0] dpv);
        logic [6:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) push_exp(s[nidx], dpv[nidx]);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic release_and_time();
        int n = 0;
        @(negedge clk); #1;
        clr = 1'b0;
        while (an == 4'hF && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n != SCAN_DIV + 1) begin
            n_fail++;
            $display("FAIL first_light: got %0d cycles after release, expected %0d", n, SCAN_DIV + 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (an != 4'hF) begin
            n_fail++;
            $display("FAIL %s_an: got %b, expected 1111", tag, an);
        end
        n_cmp++;
        if (a_to_g != 7'h7F) begin
            n_fail++;
            $display("FAIL %s_seg: got %b, expected 1111111", tag, a_to_g);
        end
        n_cmp++;
        if (dp != 1'b1) begin
            n_fail++;
            $display("FAIL %s_dp: got %b, expected 1", tag, dp);
        end
    endtask

    initial begin
        int low_cnt;
        bit bad_an;
        int exp_low;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_hold");

        // Codes 1,2,dash,9 with dp on digit 2.
        x = 16'h12A9; dp_mask = 4'b0100; blank_lz = 1'b0;
        push4(7'b1111001, 7'b0100100, 7'b0111111, 7'b0010000, 4'b1011);
        release_and_time();
        drain();

        // Leading zeros with every dp requested: suppressed digits lose dp.
        x = 16'h0050; dp_mask = 4'b1111; blank_lz = 1'b1;
        push4(7'h7F, 7'h7F, 7'b0010010, 7'b1000000, 4'b1100);
        drain();

        // All zero with suppression: only digit 0 shows.
        x = 16'h0000; dp_mask = 4'b0000; blank_lz = 1'b1;
        push4(7'h7F, 7'h7F, 7'h7F, 7'b1000000, 4'b1111);
        drain();

        // All zero without suppression.
        blank_lz = 1'b0;
        push4(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);
        drain();

        // Underscore, all-on codes and blank.
        x = 16'hCDEB;
        push4(7'b1110111, 7'b0000000, 7'b0000000, 7'b1111111, 4'b1111);
        drain();

        // Remaining digits with dp on the leftmost digit.
        x = 16'h7634; dp_mask = 4'b1000;
        push4(7'b1111000, 7'b0000010, 7'b0110000, 7'b0011001, 4'b0111);
        drain();

        // Embedded zero below a non-zero digit is not suppressed.
        x = 16'h0800; dp_mask = 4'b0110; blank_lz = 1'b1;
        push4(7'h7F, 7'b0000000, 7'b1000000, 7'b1000000, 4'b1001);
        drain();

        // Input change in mid-period takes effect only at the next advance.
        x = 16'h1111; dp_mask = 4'b0000; blank_lz = 1'b0;
        push_exp(7'b1111001, 1'b1);
        drain();
        repeat (9) begin
            @(negedge clk); #1;
        end
        x = 16'h2222;
        push_exp(7'b0100100, 1'b1);
        drain();

        // Reset in mid-scan (div_cnt=17) blanks immediately and restarts.
        repeat (16) begin
            @(negedge clk); #1;
        end
        clr = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        q.delete();
        nidx = 1;
        repeat (2) begin
            @(negedge clk); #1;
        end
        push4(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'b1111);
        release_and_time();
        drain();

        // Brightness: digit 0 just lit (div_cnt=1); watch div_cnt 2..17.
        mon_en = 1'b0;
        bright = 4'd3;
        low_cnt = 0;
        bad_an  = 1'b0;
        repeat (16) begin
            @(negedge clk); #1;
            if (an != 4'hF) begin
                low_cnt++;
                if (an != 4'b1110) bad_an = 1'b1;
            end
        end
`ifdef SEG7_PWM_EN
        exp_low = 4;
`else
        exp_low = 16;
`endif
        n_cmp++;
        if (low_cnt != exp_low) begin
            n_fail++;
            $display("FAIL pwm_duty: got %0d lit cycles of 16, expected %0d", low_cnt, exp_low);
        end
        n_cmp++;
        if (bad_an) begin
            n_fail++;
            $display("FAIL pwm_anode: wrong anode pattern while lit, expected 1110");
        end
        bright = 4'd15;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
